// File: rtl/ksa.sv
// RC4 key-scheduling pass over the 256x8 S-RAM (registered address, unregistered q).
// Optional `KSA_CYCLE_COUNT_EN adds a busy-cycle counter output `cycles`.
module ksa #(
    parameter int KEY_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_LEN-1:0]   key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
`ifdef KSA_CYCLE_COUNT_EN
    ,
    output logic [11:0]            cycles
`endif
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        WR_I,
        WR_J
    } state_t;

    state_t                 state_reg, state_next;
    logic [7:0]             i_reg, j_reg;
    logic [7:0]             si_reg, sj_reg;
    logic [8*KEY_LEN-1:0]   kreg;
    logic [KW-1:0]          kidx_reg;
    logic [7:0]             key_bytes [KEY_LEN];

    // Byte 0 is the most significant byte of the key.
    for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_key_bytes
        assign key_bytes[gi] = kreg[8*(KEY_LEN-1-gi) +: 8];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RD_I;
            RD_I:    state_next = WT_I;
            WT_I:    state_next = RD_J;
            RD_J:    state_next = WT_J;
            WT_J:    state_next = WR_I;
            WR_I:    state_next = WR_J;
            WR_J:    state_next = (i_reg == 8'hFF) ? IDLE : RD_I;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on state and datapath registers, never on rddata.
    always_comb begin
        rdy    = (state_reg == IDLE);
        wren   = (state_reg == WR_I) || (state_reg == WR_J);
        addr   = 8'd0;
        wrdata = 8'd0;
        case (state_reg)
            RD_I:    addr = i_reg;
            RD_J:    addr = j_reg;
            WR_I: begin
                addr   = i_reg;
                wrdata = sj_reg;
            end
            WR_J: begin
                addr   = j_reg;
                wrdata = si_reg;
            end
            default: begin
                addr   = 8'd0;
                wrdata = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            i_reg     <= 8'd0;
            j_reg     <= 8'd0;
            si_reg    <= 8'd0;
            sj_reg    <= 8'd0;
            kreg      <= '0;
            kidx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        kreg     <= key;
                        i_reg    <= 8'd0;
                        j_reg    <= 8'd0;
                        kidx_reg <= '0;
                    end
                end
                WT_I: begin
                    si_reg <= rddata;
                    j_reg  <= j_reg + rddata + key_bytes[kidx_reg];
                end
                WT_J: sj_reg <= rddata;
                WR_J: begin
                    // kidx tracks i mod KEY_LEN without a divider.
                    if (i_reg != 8'hFF) begin
                        i_reg    <= i_reg + 8'd1;
                        kidx_reg <= (kidx_reg == KW'(KEY_LEN-1)) ? '0 : kidx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KSA_CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= 12'd0;
        end else if (state_reg == IDLE) begin
            if (en) cycles <= 12'd0;
        end else begin
            cycles <= cycles + 12'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ksa.sv
// Scoreboarded bench for ksa: plain RC4-KSA reference model predicts the write
// stream and final S; a forked monitor pops one expected write per wren cycle.
module tb_ksa;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;
`ifdef KSA_CYCLE_COUNT_EN
    logic [11:0] cycles;
`endif

    ksa #(.KEY_LEN(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
`ifdef KSA_CYCLE_COUNT_EN
        ,
        .cycles (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S-RAM: registered address, unregistered read data.
    logic [7:0] mem [256];
    logic [7:0] addr_q;
    always @(posedge clk) begin
        addr_q <= addr;
        if (wren) mem[addr] <= wrdata;
    end
    assign rddata = mem[addr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t  exp_q [$];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   c0 = 0;
    int   ref_s [256];

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Reference RC4 key schedule on ref_s; queues the two writes of every swap.
    task automatic model_pass(input logic [23:0] k);
        int j;
        int kb;
        int si;
        int sj;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
            j  = (j + ref_s[i] + kb) % 256;
            si = ref_s[i];
            sj = ref_s[j];
            exp_q.push_back('{a: i, d: sj});
            exp_q.push_back('{a: j, d: si});
            ref_s[i] = sj;
            ref_s[j] = si;
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < 256; i++) ref_s[i] = int'(mem[i]);
    endtask

    task automatic compare_final(input string name);
        int nbad;
        int ndist;
        bit seen [256];
        nbad  = 0;
        ndist = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (int'(mem[i]) != ref_s[i]) nbad++;
            if (!seen[mem[i]]) begin
                seen[mem[i]] = 1'b1;
                ndist++;
            end
        end
        check({name, "_S_mismatches"}, nbad, 0);
        check({name, "_distinct"}, ndist, 256);
        check({name, "_sb_left"}, exp_q.size(), 0);
    endtask

    task automatic start(input logic [23:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(output int n);
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (rdy) break;
        end
        n = cyc - c0;
    endtask

    initial begin
        int n;
        int w0;
        rst_n = 1'b0;
        en    = 1'b0;
        key   = 24'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        fork
            forever begin
                @(negedge clk);
                if (rst_n && wren) begin
                    wr_cnt++;
                    check("rdy_with_wren", int'(rdy), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", int'(addr), e.a);
                        check("wr_data", int'(wrdata), e.d);
                    end
                end
            end
        join_none

        #1;
        check("rst_rdy", int'(rdy), 1);
        check("rst_wren", int'(wren), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_wrdata", int'(wrdata), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        check("idle_writes", wr_cnt - w0, 0);
        check("idle_rdy", int'(rdy), 1);

        // Pass 1: key 00033C on identity S, with intermediate S checks.
        snapshot();
        model_pass(24'h00033C);
        w0 = wr_cnt;
        start(24'h00033C);
        check("rdy_low_after_accept", int'(rdy), 0);
`ifdef KSA_CYCLE_COUNT_EN
        check("cycles_after_accept", int'(cycles), 0);
`endif
        for (int t = 0; t < 200 && wr_cnt - w0 < 2; t++) @(negedge clk);
        @(posedge clk);
        #1;
        check("i0_S0", int'(mem[0]), 0);
        check("i0_S1", int'(mem[1]), 1);
        for (int t = 0; t < 200 && wr_cnt - w0 < 4; t++) @(negedge clk);
        @(posedge clk);
        #1;
        check("i1_S1", int'(mem[1]), 8'h04);
        check("i1_S4", int'(mem[4]), 8'h01);
        for (int t = 0; t < 200 && wr_cnt - w0 < 6; t++) @(negedge clk);
        @(posedge clk);
        #1;
        check("i2_S2", int'(mem[2]), 8'h42);
        check("i2_S42", int'(mem[8'h42]), 8'h02);
        wait_done(n);
        check("p1_busy_cycles", n, 1536);
        check("p1_writes", wr_cnt - w0, 512);
`ifdef KSA_CYCLE_COUNT_EN
        check("cycles_after_done", int'(cycles), 1536);
`endif
        compare_final("p1");
        $display("[TB] pass key=00033c start=identity busy=%0d writes=%0d", n, wr_cnt - w0);

        // Key sampling: key changes one cycle after accept must be ignored.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        snapshot();
        model_pass(24'h00033C);
        w0 = wr_cnt;
        start(24'h00033C);
        @(posedge clk);
        #1;
        key = 24'hFFFFFF;
        wait_done(n);
        check("keychg_busy_cycles", n, 1536);
        compare_final("keychg");
        $display("[TB] pass key=00033c (changed to ffffff) busy=%0d writes=%0d", n, wr_cnt - w0);

        // Back-to-back with en held high throughout busy windows.
        snapshot();
        key = 24'h5A17C3;
        model_pass(24'h5A17C3);
        model_pass(24'h5A17C3);
        w0 = wr_cnt;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        wait_done(n);
        check("b2b_first_busy", n, 1536);
`ifdef KSA_CYCLE_COUNT_EN
        check("b2b_cycles_first", int'(cycles), 1536);
`endif
        @(posedge clk);
        #1;
        en = 1'b0;
        c0 = cyc;
        check("b2b_restart_rdy", int'(rdy), 0);
`ifdef KSA_CYCLE_COUNT_EN
        check("b2b_cycles_cleared", int'(cycles), 0);
`endif
        wait_done(n);
        check("b2b_second_busy", n, 1536);
        check("b2b_writes", wr_cnt - w0, 1024);
        compare_final("b2b");
        $display("[TB] pass key=5a17c3 x2 back-to-back busy=%0d writes=%0d", n, wr_cnt - w0);

        // Random keys over whatever S currently holds.
        for (int r = 0; r < 2; r++) begin
            logic [23:0] rk;
            rk = 24'($urandom);
            snapshot();
            model_pass(rk);
            w0 = wr_cnt;
            start(rk);
            wait_done(n);
            check("rand_busy_cycles", n, 1536);
            check("rand_writes", wr_cnt - w0, 512);
            compare_final("rand");
            $display("[TB] pass key=%h random busy=%0d writes=%0d", rk, n, wr_cnt - w0);
        end

        // Asynchronous reset at cycle 700 of a run, then a full pass from the leftover S.
        snapshot();
        model_pass(24'h00033C);
        start(24'h00033C);
        repeat (700) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", int'(rdy), 1);
        check("midrst_wren", int'(wren), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snapshot();
        model_pass(24'hC0FFEE);
        w0 = wr_cnt;
        start(24'hC0FFEE);
        wait_done(n);
        check("postrst_busy_cycles", n, 1536);
        check("postrst_writes", wr_cnt - w0, 512);
        compare_final("postrst");
        $display("[TB] pass key=c0ffee after mid-run reset busy=%0d writes=%0d", n, wr_cnt - w0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
